// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared types and constants for the SIPO frame receiver
//
// Purpose : FSM state encoding, legal WIDTH range and the bit-counter width
//           helper used by sipo_frame_receiver and sipo_shift_core.
// Ports   : none (package).

package sipo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } sipo_state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;

    // The counter must be able to hold WIDTH itself (parity build parks at WIDTH).
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_frame_receiver_if.sv
// rtl/sipo_frame_receiver_if.sv - parallel word output port of the SIPO receiver
//
// Purpose : valid/ready bundle carrying reassembled words downstream.
// Signals : dout     - received word
//           dout_vld - dout holds an unconsumed word
//           dout_rdy - consumer accepts the word when dout_vld=1
// Modports: master (receiver side), slave (consumer side).

interface sipo_frame_receiver_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic             dout_rdy;

    modport master (output dout, output dout_vld, input dout_rdy);
    modport slave  (input dout, input dout_vld, output dout_rdy);
endinterface

// File: rtl/sipo_shift_core.sv
// rtl/sipo_shift_core.sv - WIDTH-bit bidirectional shift register for the SIPO receiver
//
// Purpose : shifts sdi in at the LSB (msb_first=1) or MSB (msb_first=0).
//           clear together with shift_en restarts the register from zero so a
//           new frame never inherits bits of a discarded one.
// Ports   : clk, rst (async, active high), shift_en, clear, msb_first, sdi,
//           tap_next - 1: q shows the value being shifted in this cycle,
//                      0: q shows the registered contents
//           q        - selected shift register view

module sipo_shift_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             clear,
    input  logic             msb_first,
    input  logic             sdi,
    input  logic             tap_next,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] sr_nxt;

    always_comb begin
        base   = clear ? '0 : sr;
        sr_nxt = msb_first ? {base[WIDTH-2:0], sdi} : {sdi, base[WIDTH-1:1]};
        q      = tap_next ? sr_nxt : sr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (shift_en) begin
            sr <= sr_nxt;
        end else if (clear) begin
            sr <= '0;
        end
    end

endmodule

// File: rtl/sipo_frame_receiver.sv
// rtl/sipo_frame_receiver.sv - framed serial-in/parallel-out word receiver
//
// Purpose : reassembles WIDTH-bit words (WIDTH 2..16) from a strobed serial
//           stream with start-of-frame marker, either bit order, and presents
//           them on a valid/ready port with sticky overrun detection.
// Option  : SIPO_PARITY_CHECK_EN - when defined, each frame carries one extra
//           even-parity bit after the data and parity_err reports its result.
// Ports   : clk, rst (async, active high), ena, sdi, bit_vld, sof, msb_first,
//           clr_err, out_if (master: dout/dout_vld/dout_rdy),
//           busy, frame_abort, overrun, parity_err.

module sipo_frame_receiver
    import sipo_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ena,
    input  logic                         sdi,
    input  logic                         bit_vld,
    input  logic                         sof,
    input  logic                         msb_first,
    input  logic                         clr_err,
    sipo_frame_receiver_if.master        out_if,
    output logic                         busy,
    output logic                         frame_abort,
    output logic                         overrun,
    output logic                         parity_err
);

    localparam int CW = cnt_width(WIDTH);

    sipo_state_t      state;
    logic [CW-1:0]    cnt;
    logic             msb_lat;
    logic [WIDTH-1:0] dout_q;
    logic             dout_vld_q;

    logic             accept;
    logic             start;
    logic             data_bit;
    logic             data_last;
    logic             msb_eff;
    logic             word_done;
    logic             drop;
    logic             load;
    logic [WIDTH-1:0] word;
    logic             tap_next;

    assign accept    = ena & bit_vld;
    assign start     = accept & sof;
    assign data_bit  = accept & ~sof & (state == ST_SHIFT);
    assign data_last = data_bit & (cnt == CW'(WIDTH - 1));
    // The bit order of the first bit comes straight from the pin; later bits
    // use the value latched when the frame started.
    assign msb_eff   = start ? msb_first : msb_lat;

`ifdef SIPO_PARITY_CHECK_EN
    logic par_bit;
    logic word_bad;
    // The data is already complete in the register when the parity bit arrives.
    assign tap_next  = 1'b0;
    assign par_bit   = accept & ~sof & (state == ST_PARITY);
    assign word_done = par_bit;
    assign word_bad  = (^word) ^ sdi;
`else
    // The completing data bit is still being shifted, so deliver the next value.
    assign tap_next  = 1'b1;
    assign word_done = data_last;
`endif

    // A finished word is dropped only if the previous one is still pending
    // and not being consumed in this same cycle.
    assign drop = word_done & dout_vld_q & ~out_if.dout_rdy;
    assign load = word_done & ~drop;

    sipo_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (start | data_bit),
        .clear     (start),
        .msb_first (msb_eff),
        .sdi       (sdi),
        .tap_next  (tap_next),
        .q         (word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            msb_lat     <= 1'b0;
            busy        <= 1'b0;
            frame_abort <= 1'b0;
            dout_q      <= '0;
            dout_vld_q  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_abort <= start & (state != ST_IDLE);

            if (start) begin
                state   <= ST_SHIFT;
                cnt     <= CW'(1);
                msb_lat <= msb_first;
                busy    <= 1'b1;
            end else if (data_bit) begin
                if (data_last) begin
`ifdef SIPO_PARITY_CHECK_EN
                    state <= ST_PARITY;
                    cnt   <= cnt + CW'(1);
`else
                    state <= ST_IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
`endif
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
`ifdef SIPO_PARITY_CHECK_EN
            else if (par_bit) begin
                state <= ST_IDLE;
                cnt   <= '0;
                busy  <= 1'b0;
            end
`endif

            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end

            if (load) begin
                dout_q     <= word;
                dout_vld_q <= 1'b1;
            end else if (dout_vld_q && out_if.dout_rdy) begin
                dout_vld_q <= 1'b0;
            end
        end
    end

`ifdef SIPO_PARITY_CHECK_EN
    // Loading a word with bad parity outranks a simultaneous clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else if (load) begin
            parity_err <= word_bad;
        end else if (clr_err) begin
            parity_err <= 1'b0;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    assign out_if.dout     = dout_q;
    assign out_if.dout_vld = dout_vld_q;

endmodule
